// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: pixel-rate enable, h/v scan counters, sync pulses,
// active-video flag and frame / vertical-blank strobes, all registered with zero skew.
module vga_timing_gen #(
  parameter int unsigned CLK_DIV  = 4,
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter bit          SYNC_POL = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic       pix_en,
  output logic [9:0] h_cnt,
  output logic [9:0] v_cnt,
  output logic       valid,
  output logic       hsync,
  output logic       vsync,
  output logic       frame_start,
  output logic       vblank_start
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned DivW    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DivW-1:0] DivLast = DivW'(CLK_DIV - 1);
  localparam logic [9:0]      HLast   = 10'(H_TOTAL - 1);
  localparam logic [9:0]      VLast   = 10'(V_TOTAL - 1);

  // Region bounds are 11 bits wide so an upper bound of exactly 1024 stays representable.
  localparam logic [10:0] HActEnd = 11'(H_ACTIVE);
  localparam logic [10:0] HsStart = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HsEnd   = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] VActEnd = 11'(V_ACTIVE);
  localparam logic [10:0] VsStart = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] VsEnd   = 11'(V_ACTIVE + V_FP + V_SYNC);

  if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_totals
    $error("vga_timing_gen: H_TOTAL and V_TOTAL must not exceed 1024");
  end
  if (CLK_DIV < 1) begin : g_bad_div
    $error("vga_timing_gen: CLK_DIV must be at least 1");
  end

  logic [DivW-1:0] div_q, div_d;
  logic            pix_en_q, pix_en_d;
  logic [9:0]      h_q, h_d;
  logic [9:0]      v_q, v_d;
  logic            valid_q, valid_d;
  logic            hsync_q, hsync_d;
  logic            vsync_q, vsync_d;
  logic            frame_q, frame_d;
  logic            vblank_q, vblank_d;
  logic [10:0]     h_ext, v_ext;

  always_comb begin
    div_d    = (div_q == DivLast) ? '0 : div_q + 1'b1;
    // pix_en is its own flop so the output never glitches on divider transitions.
    pix_en_d = (div_d == DivLast);

    h_d = h_q;
    v_d = v_q;
    if (pix_en_q) begin
      if (h_q == HLast) begin
        h_d = '0;
        v_d = (v_q == VLast) ? '0 : v_q + 1'b1;
      end else begin
        h_d = h_q + 1'b1;
      end
    end

    // Flags are decoded from the next counter values so they line up with h_cnt/v_cnt.
    h_ext    = {1'b0, h_d};
    v_ext    = {1'b0, v_d};
    valid_d  = (h_ext < HActEnd) && (v_ext < VActEnd);
    hsync_d  = ((h_ext >= HsStart) && (h_ext < HsEnd)) ? SYNC_POL : ~SYNC_POL;
    vsync_d  = ((v_ext >= VsStart) && (v_ext < VsEnd)) ? SYNC_POL : ~SYNC_POL;
    frame_d  = pix_en_q && (h_d == '0) && (v_d == '0);
    vblank_d = pix_en_q && (h_d == '0) && (v_ext == VActEnd);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q    <= '0;
      pix_en_q <= (CLK_DIV == 1);
      h_q      <= HLast;
      v_q      <= VLast;
      valid_q  <= 1'b0;
      hsync_q  <= ~SYNC_POL;
      vsync_q  <= ~SYNC_POL;
      frame_q  <= 1'b0;
      vblank_q <= 1'b0;
    end else begin
      div_q    <= div_d;
      pix_en_q <= pix_en_d;
      h_q      <= h_d;
      v_q      <= v_d;
      valid_q  <= valid_d;
      hsync_q  <= hsync_d;
      vsync_q  <= vsync_d;
      frame_q  <= frame_d;
      vblank_q <= vblank_d;
    end
  end

  assign pix_en       = pix_en_q;
  assign h_cnt        = h_q;
  assign v_cnt        = v_q;
  assign valid        = valid_q;
  assign hsync        = hsync_q;
  assign vsync        = vsync_q;
  assign frame_start  = frame_q;
  assign vblank_start = vblank_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Self-checking bench for vga_timing_gen: three instances (default timing, a shrunken raster
// for full-frame runs, and CLK_DIV=1 with positive sync) checked against a closed-form model.
module tb_vga_timing_gen;

  typedef struct packed {
    logic       pix_en;
    logic [9:0] h;
    logic [9:0] v;
    logic       valid;
    logic       hsync;
    logic       vsync;
    logic       fs;
    logic       vb;
  } obs_t;

  typedef struct {
    int div; int ha; int hfp; int hs; int hbp;
    int va; int vfp; int vs; int vbp; bit pol;
  } cfg_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n0 = 1'b0, rst_n1 = 1'b0, rst_n2 = 1'b0;
  logic       pe0, val0, hs0, vs0, fs0, vb0;
  logic       pe1, val1, hs1, vs1, fs1, vb1;
  logic       pe2, val2, hs2, vs2, fs2, vb2;
  logic [9:0] h0, v0, h1, v1, h2, v2;

  obs_t   obs [3];
  longint k   [3];
  int     checks = 0;
  int     errors = 0;

  vga_timing_gen u_std (
    .clk(clk), .rst_n(rst_n0), .pix_en(pe0), .h_cnt(h0), .v_cnt(v0), .valid(val0),
    .hsync(hs0), .vsync(vs0), .frame_start(fs0), .vblank_start(vb0)
  );

  vga_timing_gen #(
    .CLK_DIV(2), .H_ACTIVE(20), .H_FP(2), .H_SYNC(4), .H_BP(3),
    .V_ACTIVE(12), .V_FP(2), .V_SYNC(2), .V_BP(3), .SYNC_POL(1'b0)
  ) u_small (
    .clk(clk), .rst_n(rst_n1), .pix_en(pe1), .h_cnt(h1), .v_cnt(v1), .valid(val1),
    .hsync(hs1), .vsync(vs1), .frame_start(fs1), .vblank_start(vb1)
  );

  vga_timing_gen #(.CLK_DIV(1), .SYNC_POL(1'b1)) u_div1 (
    .clk(clk), .rst_n(rst_n2), .pix_en(pe2), .h_cnt(h2), .v_cnt(v2), .valid(val2),
    .hsync(hs2), .vsync(vs2), .frame_start(fs2), .vblank_start(vb2)
  );

  assign obs[0] = {pe0, h0, v0, val0, hs0, vs0, fs0, vb0};
  assign obs[1] = {pe1, h1, v1, val1, hs1, vs1, fs1, vb1};
  assign obs[2] = {pe2, h2, v2, val2, hs2, vs2, fs2, vb2};

  function automatic cfg_t cfg_of(int i);
    cfg_t c;
    case (i)
      0:       c = '{4, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0};
      1:       c = '{2, 20, 2, 4, 3, 12, 2, 2, 3, 1'b0};
      default: c = '{1, 640, 16, 96, 48, 480, 10, 2, 33, 1'b1};
    endcase
    return c;
  endfunction

  // k = clock edges since reset release; n = pixels elapsed; pixel n lands at raster index n-1.
  function automatic obs_t model(cfg_t c, longint kk);
    obs_t   e;
    longint ht, vt, n, p;
    int     h, v;
    bit     upd;
    ht  = longint'(c.ha + c.hfp + c.hs + c.hbp);
    vt  = longint'(c.va + c.vfp + c.vs + c.vbp);
    n   = kk / c.div;
    upd = (kk > 0) && (kk % c.div == 0);
    if (n == 0) begin
      h = int'(ht - 1);
      v = int'(vt - 1);
    end else begin
      p = (n - 1) % (ht * vt);
      h = int'(p % ht);
      v = int'(p / ht);
    end
    e.pix_en = ((kk % c.div) == longint'(c.div - 1));
    e.h      = 10'(h);
    e.v      = 10'(v);
    e.valid  = (h < c.ha) && (v < c.va);
    e.hsync  = (h >= c.ha + c.hfp && h < c.ha + c.hfp + c.hs) ? c.pol : ~c.pol;
    e.vsync  = (v >= c.va + c.vfp && v < c.va + c.vfp + c.vs) ? c.pol : ~c.pol;
    e.fs     = upd && h == 0 && v == 0;
    e.vb     = upd && h == 0 && v == c.va;
    return e;
  endfunction

  function automatic string fmt(obs_t o);
    return $sformatf("pe=%0b h=%0d v=%0d valid=%0b hs=%0b vs=%0b fs=%0b vb=%0b",
                     o.pix_en, o.h, o.v, o.valid, o.hsync, o.vsync, o.fs, o.vb);
  endfunction

  task automatic step(int d);
    @(negedge clk);
    k[d]++;
  endtask

  task automatic test_reset();
    obs_t e;
    rst_n0 = 1'b0; rst_n1 = 1'b0; rst_n2 = 1'b0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      e = model(cfg_of(i), 0);
      checks++;
      if (obs[i] !== e) begin
        errors++;
        $display("FAIL reset_state dut%0d got %s exp %s", i, fmt(obs[i]), fmt(e));
      end
    end
    rst_n0 = 1'b1;
    k[0]   = 0;
    for (int c = 1; c <= 6; c++) begin
      step(0);
      e = model(cfg_of(0), k[0]);
      checks++;
      if (obs[0] !== e) begin
        errors++;
        $display("FAIL reset_release k=%0d got %s exp %s", k[0], fmt(obs[0]), fmt(e));
      end
      checks++;
      if (obs[0].pix_en !== (c == 3 ? 1'b1 : 1'b0)) begin
        errors++;
        $display("FAIL first_pix_en edge=%0d got %0b", c, obs[0].pix_en);
      end
      if (c == 4) begin
        checks++;
        if (obs[0].h !== 10'd0 || obs[0].v !== 10'd0 || obs[0].valid !== 1'b1
            || obs[0].fs !== 1'b1) begin
          errors++;
          $display("FAIL first_pixel got %s exp h=0 v=0 valid=1 fs=1", fmt(obs[0]));
        end
      end
    end
  endtask

  task automatic test_line();
    obs_t e, prev;
    int   hs_clks = 0;
    bit   wrapped = 1'b0;
    prev = obs[0];
    for (int c = 0; c < 3300; c++) begin
      step(0);
      e = model(cfg_of(0), k[0]);
      checks++;
      if (obs[0] !== e) begin
        errors++;
        $display("FAIL line_scan k=%0d got %s exp %s", k[0], fmt(obs[0]), fmt(e));
      end
      if (obs[0].v == 10'd0 && obs[0].hsync == 1'b0) hs_clks++;
      if (prev.hsync == 1'b1 && obs[0].hsync == 1'b0) begin
        checks++;
        if (obs[0].h !== 10'd656) begin
          errors++;
          $display("FAIL hsync_start got h=%0d exp 656", obs[0].h);
        end
      end
      if (prev.valid == 1'b1 && obs[0].valid == 1'b0) begin
        checks++;
        if (obs[0].h !== 10'd640) begin
          errors++;
          $display("FAIL valid_fall got h=%0d exp 640", obs[0].h);
        end
      end
      if (prev.h == 10'd799 && prev.v == 10'd0 && obs[0].h == 10'd0 && obs[0].v == 10'd1)
        wrapped = 1'b1;
      prev = obs[0];
    end
    checks++;
    if (hs_clks != 96 * 4) begin
      errors++;
      $display("FAIL hsync_width got %0d clks exp %0d", hs_clks, 96 * 4);
    end
    checks++;
    if (!wrapped) begin
      errors++;
      $display("FAIL line_wrap got no 799->0 with v 0->1 exp one");
    end
  endtask

  task automatic test_clk_div1();
    obs_t   e;
    longint last_h0 = -1;
    int     periods = 0;
    rst_n2 = 1'b1;
    k[2]   = 0;
    for (int c = 0; c < 1700; c++) begin
      step(2);
      e = model(cfg_of(2), k[2]);
      checks++;
      if (obs[2] !== e || obs[2].pix_en !== 1'b1) begin
        errors++;
        $display("FAIL div1_scan k=%0d got %s exp %s", k[2], fmt(obs[2]), fmt(e));
      end
      if (obs[2].h == 10'd0) begin
        if (last_h0 >= 0) begin
          periods++;
          checks++;
          if (k[2] - last_h0 != 800) begin
            errors++;
            $display("FAIL div1_line_period got %0d exp 800", k[2] - last_h0);
          end
        end
        last_h0 = k[2];
      end
    end
    checks++;
    if (periods != 2) begin
      errors++;
      $display("FAIL div1_line_count got %0d exp 2", periods);
    end
  endtask

  task automatic test_frame();
    obs_t   e;
    longint fs_k [$];
    int     vs_clks = 0;
    int     vb_n = 0;
    longint f = 29 * 19 * 2;
    rst_n1 = 1'b1;
    k[1]   = 0;
    for (int c = 0; c < 2 * f + 5; c++) begin
      step(1);
      e = model(cfg_of(1), k[1]);
      checks++;
      if (obs[1] !== e) begin
        errors++;
        $display("FAIL frame_scan k=%0d got %s exp %s", k[1], fmt(obs[1]), fmt(e));
      end
      if (obs[1].vsync == 1'b0) vs_clks++;
      if (obs[1].fs) fs_k.push_back(k[1]);
      if (obs[1].vb) begin
        vb_n++;
        checks++;
        if (obs[1].h !== 10'd0 || obs[1].v !== 10'd12) begin
          errors++;
          $display("FAIL vblank_pos got h=%0d v=%0d exp 0,12", obs[1].h, obs[1].v);
        end
      end
    end
    checks++;
    if (vs_clks != 2 * (2 * 29 * 2)) begin
      errors++;
      $display("FAIL vsync_width got %0d exp %0d", vs_clks, 2 * (2 * 29 * 2));
    end
    checks++;
    if (vb_n != 2) begin
      errors++;
      $display("FAIL vblank_count got %0d exp 2", vb_n);
    end
    checks++;
    if (fs_k.size() != 3) begin
      errors++;
      $display("FAIL frame_start_count got %0d exp 3", fs_k.size());
    end else begin
      for (int i = 1; i < 3; i++) begin
        checks++;
        if (fs_k[i] - fs_k[i-1] != f) begin
          errors++;
          $display("FAIL frame_period got %0d exp %0d", fs_k[i] - fs_k[i-1], f);
        end
      end
    end
  endtask

  task automatic test_mid_reset();
    obs_t e;
    bit   seen_fs = 1'b0;
    rst_n1 = 1'b0;
    @(negedge clk);
    rst_n1 = 1'b1;
    k[1]   = 0;
    while (k[1] < (5 * 29 + 10 + 1) * 2) step(1);
    checks++;
    if (obs[1].h !== 10'd10 || obs[1].v !== 10'd5) begin
      errors++;
      $display("FAIL mid_target got h=%0d v=%0d exp 10,5", obs[1].h, obs[1].v);
    end
    #2 rst_n1 = 1'b0;
    #1;
    checks++;
    if (obs[1].h !== 10'd28 || obs[1].v !== 10'd18 || obs[1].valid !== 1'b0
        || obs[1].hsync !== 1'b1 || obs[1].vsync !== 1'b1 || obs[1].fs !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset got %s exp h=28 v=18 valid=0 hs=1 vs=1", fmt(obs[1]));
    end
    @(negedge clk);
    rst_n1 = 1'b1;
    k[1]   = 0;
    for (int c = 0; c < 40; c++) begin
      step(1);
      e = model(cfg_of(1), k[1]);
      checks++;
      if (obs[1] !== e) begin
        errors++;
        $display("FAIL mid_restart k=%0d got %s exp %s", k[1], fmt(obs[1]), fmt(e));
      end
      if (obs[1].fs && k[1] == 2) seen_fs = 1'b1;
    end
    checks++;
    if (!seen_fs) begin
      errors++;
      $display("FAIL restart_frame_start got none exp pulse at first pixel");
    end
  endtask

  task automatic test_scoreboard();
    obs_t e;
    obs_t prev;
    int   len, off;
    for (int it = 0; it < 8; it++) begin
      len  = $urandom_range(1, 2 * 29 * 19 * 2);
      prev = obs[1];
      for (int c = 0; c < len; c++) begin
        step(1);
        e = model(cfg_of(1), k[1]);
        checks++;
        if (obs[1] !== e) begin
          errors++;
          $display("FAIL sb_model k=%0d got %s exp %s", k[1], fmt(obs[1]), fmt(e));
        end
        checks++;
        if (obs[1].valid !== (obs[1].h < 10'd20 && obs[1].v < 10'd12)
            || obs[1].h >= 10'd29 || obs[1].v >= 10'd19
            || (prev.fs && obs[1].fs) || (prev.vb && obs[1].vb)) begin
          errors++;
          $display("FAIL sb_invariant k=%0d got %s prev %s", k[1], fmt(obs[1]), fmt(prev));
        end
        prev = obs[1];
      end
      off = $urandom_range(1, 3);
      #(off) rst_n1 = 1'b0;
      #1;
      e = model(cfg_of(1), 0);
      checks++;
      if (obs[1] !== e) begin
        errors++;
        $display("FAIL sb_async_reset got %s exp %s", fmt(obs[1]), fmt(e));
      end
      repeat ($urandom_range(1, 3)) @(negedge clk);
      rst_n1 = 1'b1;
      k[1]   = 0;
    end
  endtask

  initial begin
    k[0] = 0; k[1] = 0; k[2] = 0;
    test_reset();
    test_line();
    test_clk_div1();
    test_frame();
    test_mid_reset();
    test_scoreboard();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
